// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the in-order TinyRV1 pipeline: bypass selects, load-use stalls,
// X-stage freezes and W-stage RF write controls. Define HAZARD_SQUASH_EN to enable redirect squashing.
module pipe_hazard_ctrl #(
  parameter int NSTG   = 3,
  parameter int RA_W   = 5,
  parameter int LD_STG = 2,
  parameter int CNT_W  = 16,
  localparam int SEL_W = $clog2(NSTG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_inst_val,
  input  logic             d_rs1_en,
  input  logic             d_rs2_en,
  input  logic [RA_W-1:0]  d_rs1,
  input  logic [RA_W-1:0]  d_rs2,
  input  logic             d_wen,
  input  logic [RA_W-1:0]  d_rd,
  input  logic             d_is_load,
  input  logic             x_busy,
  input  logic             redirect_d,
  input  logic             redirect_x,
  output logic             reg_en_F,
  output logic             reg_en_D,
  output logic             squash_F,
  output logic             squash_D,
  output logic [SEL_W-1:0] op1_byp_sel,
  output logic [SEL_W-1:0] op2_byp_sel,
  output logic             d_live,
  output logic             rf_wen_W,
  output logic [RA_W-1:0]  rf_waddr_W,
  output logic [CNT_W-1:0] stall_cnt
);

  // Per-stage destination records; index 1 is X, index NSTG is W.
  logic              r_val_fd;
  logic [NSTG:1]     r_val;
  logic [NSTG:1]     r_wen;
  logic [NSTG:1]     r_ld;
  logic [RA_W-1:0]   r_rd [1:NSTG];
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_val_d;
  logic              w_d_live;
  logic              w_stall_d;
  logic              w_freeze;
  logic              w_reg_en;
  logic              w_squash_d;
  logic              w_squash_f;
  logic              w_lu1;
  logic              w_lu2;
  logic [SEL_W-1:0]  w_sel1;
  logic [SEL_W-1:0]  w_sel2;

  assign w_val_d  = r_val_fd & d_inst_val;
  assign w_d_live = w_val_d & ~w_squash_d;
  assign w_freeze = x_busy;

  // Scan oldest to youngest so the youngest matching producer overrides older ones.
  always_comb begin
    w_sel1 = '0;
    w_lu1  = 1'b0;
    w_sel2 = '0;
    w_lu2  = 1'b0;
    for (int k = NSTG; k >= 1; k--) begin
      if (r_val[k] && r_wen[k] && (r_rd[k] != '0)) begin
        if (d_rs1_en && (r_rd[k] == d_rs1)) begin
          w_lu1  = r_ld[k] && (k < LD_STG);
          w_sel1 = w_lu1 ? '0 : SEL_W'(k);
        end
        if (d_rs2_en && (r_rd[k] == d_rs2)) begin
          w_lu2  = r_ld[k] && (k < LD_STG);
          w_sel2 = w_lu2 ? '0 : SEL_W'(k);
        end
      end
    end
  end

  assign w_stall_d = w_val_d & (w_lu1 | w_lu2) & ~w_squash_d;
  assign w_reg_en  = ~(w_stall_d | w_freeze);

`ifdef HAZARD_SQUASH_EN
  // A taken branch in X only counts once the multi-cycle unit has finished.
  assign w_squash_d = r_val[1] & redirect_x & ~x_busy;
  assign w_squash_f = w_squash_d | (w_val_d & redirect_d & ~w_stall_d & ~w_freeze);
`else
  logic w_unused_redirect;
  assign w_unused_redirect = redirect_d | redirect_x;
  assign w_squash_d        = 1'b0;
  assign w_squash_f        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val_fd    <= 1'b0;
      r_val       <= '0;
      r_wen       <= '0;
      r_ld        <= '0;
      r_stall_cnt <= '0;
      for (int k = 1; k <= NSTG; k++) r_rd[k] <= '0;
    end else begin
      if (w_freeze) begin
        // X holds its instruction, a bubble drops into stage 2, older stages drain.
        r_val[2] <= 1'b0;
        for (int k = 3; k <= NSTG; k++) begin
          r_val[k] <= r_val[k-1];
          r_wen[k] <= r_wen[k-1];
          r_ld[k]  <= r_ld[k-1];
          r_rd[k]  <= r_rd[k-1];
        end
      end else begin
        r_val[1] <= w_d_live & ~w_stall_d;
        r_wen[1] <= d_wen;
        r_ld[1]  <= d_is_load;
        r_rd[1]  <= d_rd;
        for (int k = 2; k <= NSTG; k++) begin
          r_val[k] <= r_val[k-1];
          r_wen[k] <= r_wen[k-1];
          r_ld[k]  <= r_ld[k-1];
          r_rd[k]  <= r_rd[k-1];
        end
      end

      if (w_squash_f) r_val_fd <= 1'b0;
      else if (w_reg_en) r_val_fd <= 1'b1;

      if ((w_stall_d | w_freeze) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign reg_en_F    = w_reg_en;
  assign reg_en_D    = w_reg_en;
  assign squash_F    = w_squash_f;
  assign squash_D    = w_squash_d;
  assign op1_byp_sel = w_sel1;
  assign op2_byp_sel = w_sel2;
  assign d_live      = w_d_live;
  assign rf_wen_W    = r_val[NSTG] & r_wen[NSTG] & (r_rd[NSTG] != '0);
  assign rf_waddr_W  = r_rd[NSTG];
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic, all outputs
// compared each cycle against a queue-based pipeline model.
module tb_pipe_hazard_ctrl;
  localparam int NSTG   = 3;
  localparam int RA_W   = 5;
  localparam int LD_STG = 2;
  localparam int CNT_W  = 4;
  localparam int SEL_W  = $clog2(NSTG + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             d_inst_val, d_rs1_en, d_rs2_en, d_wen, d_is_load;
  logic [RA_W-1:0]  d_rs1, d_rs2, d_rd;
  logic             x_busy, redirect_d, redirect_x;
  logic             reg_en_F, reg_en_D, squash_F, squash_D, d_live, rf_wen_W;
  logic [SEL_W-1:0] op1_byp_sel, op2_byp_sel;
  logic [RA_W-1:0]  rf_waddr_W;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.NSTG(NSTG), .RA_W(RA_W), .LD_STG(LD_STG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .d_inst_val(d_inst_val), .d_rs1_en(d_rs1_en), .d_rs2_en(d_rs2_en),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_wen(d_wen), .d_rd(d_rd), .d_is_load(d_is_load),
    .x_busy(x_busy), .redirect_d(redirect_d), .redirect_x(redirect_x),
    .reg_en_F(reg_en_F), .reg_en_D(reg_en_D), .squash_F(squash_F), .squash_D(squash_D),
    .op1_byp_sel(op1_byp_sel), .op2_byp_sel(op2_byp_sel), .d_live(d_live),
    .rf_wen_W(rf_wen_W), .rf_waddr_W(rf_waddr_W), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: pipe[0] is stage 1 (X), pipe[NSTG-1] is W
  typedef struct packed {
    logic            val;
    logic            wen;
    logic [RA_W-1:0] rd;
    logic            ld;
  } rec_t;

  rec_t pipe[$];
  logic m_val_fd;
  int   m_cnt;
  logic e_reg_en, e_sq_f, e_sq_d, e_live, e_stall, e_rf_wen;
  int   e_sel1, e_sel2, e_waddr;

  function automatic void m_reset();
    pipe.delete();
    for (int i = 0; i < NSTG; i++) pipe.push_back('0);
    m_val_fd = 1'b0;
    m_cnt    = 0;
  endfunction

  function automatic int youngest(input logic [RA_W-1:0] s);
    for (int i = 0; i < NSTG; i++)
      if (pipe[i].val && pipe[i].wen && pipe[i].rd == s && s != 0) return i + 1;
    return 0;
  endfunction

  function automatic void lookup(input logic en, input logic [RA_W-1:0] s,
                                 output int sel, output logic lu);
    int k;
    k   = en ? youngest(s) : 0;
    lu  = (k != 0) && pipe[k-1].ld && (k < LD_STG);
    sel = lu ? 0 : k;
  endfunction

  function automatic void model_eval();
    logic val_d, lu1, lu2;
    val_d = m_val_fd & d_inst_val;
`ifdef HAZARD_SQUASH_EN
    e_sq_d = pipe[0].val & redirect_x & ~x_busy;
`else
    e_sq_d = 1'b0;
`endif
    lookup(d_rs1_en, d_rs1, e_sel1, lu1);
    lookup(d_rs2_en, d_rs2, e_sel2, lu2);
    e_stall  = val_d & (lu1 | lu2) & ~e_sq_d;
    e_reg_en = !(e_stall | x_busy);
`ifdef HAZARD_SQUASH_EN
    e_sq_f = e_sq_d | (val_d & redirect_d & ~e_stall & ~x_busy);
`else
    e_sq_f = 1'b0;
`endif
    e_live   = val_d & ~e_sq_d;
    e_rf_wen = pipe[NSTG-1].val & pipe[NSTG-1].wen & (pipe[NSTG-1].rd != 0);
    e_waddr  = int'(pipe[NSTG-1].rd);
  endfunction

  function automatic void model_step();
    rec_t r;
    if (e_stall || x_busy) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    if (x_busy) begin
      r = pipe[1];
      r.val = 1'b0;
      void'(pipe.pop_back());
      pipe.insert(1, r);
    end else begin
      r = '{val: e_live & ~e_stall, wen: d_wen, rd: d_rd, ld: d_is_load};
      pipe.push_front(r);
      void'(pipe.pop_back());
    end
    if (e_sq_f) m_val_fd = 1'b0;
    else if (e_reg_en) m_val_fd = 1'b1;
  endfunction

  // per-cycle compare at the falling edge
  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("reg_en_F", reg_en_F, e_reg_en);
    chk("reg_en_D", reg_en_D, e_reg_en);
    chk("squash_F", squash_F, e_sq_f);
    chk("squash_D", squash_D, e_sq_d);
    chk("op1_byp_sel", op1_byp_sel, e_sel1);
    chk("op2_byp_sel", op2_byp_sel, e_sel2);
    chk("d_live", d_live, e_live);
    chk("rf_wen_W", rf_wen_W, e_rf_wen);
    if (e_rf_wen) chk("rf_waddr_W", rf_waddr_W, e_waddr);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic advance();
    if (!rst) m_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic set_d(input logic v, input logic e1, input int s1, input logic e2, input int s2,
                       input logic w, input int rd, input logic ld);
    d_inst_val = v;
    d_rs1_en   = e1;
    d_rs1      = RA_W'(s1);
    d_rs2_en   = e2;
    d_rs2      = RA_W'(s2);
    d_wen      = w;
    d_rd       = RA_W'(rd);
    d_is_load  = ld;
  endtask

  task automatic nops(input int n);
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  initial begin
    rst = 1'b0;
    x_busy = 1'b0;
    redirect_d = 1'b0;
    redirect_x = 1'b0;
    set_d(1, 1, 1, 1, 1, 1, 1, 0);
    m_reset();
    @(posedge clk);
    #1;

    // reset values
    sample();
    chk("rst_reg_en_F", reg_en_F, 1);
    chk("rst_reg_en_D", reg_en_D, 1);
    chk("rst_squash_F", squash_F, 0);
    chk("rst_squash_D", squash_D, 0);
    chk("rst_op1_sel", op1_byp_sel, 0);
    chk("rst_d_live", d_live, 0);
    chk("rst_rf_wen_W", rf_wen_W, 0);
    chk("rst_rf_waddr_W", rf_waddr_W, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    advance();

    // first cycle after release ignores D
    rst = 1'b1;
    set_d(1, 0, 0, 0, 0, 1, 1, 0);
    sample();
    chk("post_rst_d_live", d_live, 0);
    advance();

    // bypass chain
    set_d(1, 0, 0, 0, 0, 1, 1, 0);
    sample();
    chk("addi_d_live", d_live, 1);
    advance();
    set_d(1, 1, 1, 1, 1, 1, 2, 0);
    sample();
    chk("chain_op1_sel1", op1_byp_sel, 1);
    chk("chain_op2_sel1", op2_byp_sel, 1);
    advance();
    set_d(1, 1, 1, 0, 0, 0, 0, 0);
    sample();
    chk("chain_sel2", op1_byp_sel, 2);
    advance();
    sample();
    chk("chain_sel3", op1_byp_sel, 3);
    chk("chain_w_wen", rf_wen_W, 1);
    chk("chain_w_addr", rf_waddr_W, 1);
    advance();
    sample();
    chk("chain_sel0", op1_byp_sel, 0);
    advance();
    nops(3);

    // load-use
    set_d(1, 0, 0, 0, 0, 1, 3, 1);
    sample();
    advance();
    set_d(1, 1, 3, 1, 0, 1, 4, 0);
    sample();
    chk("lu_reg_en_D", reg_en_D, 0);
    chk("lu_reg_en_F", reg_en_F, 0);
    chk("lu_op1_sel", op1_byp_sel, 0);
    advance();
    sample();
    chk("lu_after_sel", op1_byp_sel, 2);
    chk("lu_after_reg_en", reg_en_D, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    advance();
    nops(3);

    // same-rd priority
    set_d(1, 0, 0, 0, 0, 1, 5, 0);
    sample();
    advance();
    sample();
    advance();
    set_d(1, 1, 5, 0, 0, 0, 0, 0);
    sample();
    chk("same_rd_sel", op1_byp_sel, 1);
    advance();
    nops(3);

    // rd = 0
    set_d(1, 0, 0, 0, 0, 1, 0, 0);
    sample();
    advance();
    set_d(1, 1, 0, 0, 0, 0, 0, 0);
    sample();
    chk("x0_sel", op1_byp_sel, 0);
    advance();
    nops(1);
    sample();
    chk("x0_rf_wen", rf_wen_W, 0);
    advance();
    nops(2);

    // freeze
    set_d(1, 0, 0, 0, 0, 1, 6, 0);
    sample();
    advance();
    set_d(1, 0, 0, 0, 0, 0, 0, 0);
    x_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("frz_reg_en", reg_en_F, 0);
      advance();
    end
    x_busy = 1'b0;
    sample();
    chk("frz_stall_cnt", stall_cnt, 4);
    chk("frz_reg_en_back", reg_en_D, 1);
    advance();
    sample();
    advance();
    sample();
    chk("frz_mul_w_wen", rf_wen_W, 1);
    chk("frz_mul_w_addr", rf_waddr_W, 6);
    advance();
    nops(3);

    // redirects
    set_d(1, 1, 1, 1, 2, 0, 0, 0);
    sample();
    advance();
    set_d(1, 0, 0, 0, 0, 1, 8, 0);
    redirect_x = 1'b1;
    sample();
`ifdef HAZARD_SQUASH_EN
    chk("bne_squash_D", squash_D, 1);
    chk("bne_squash_F", squash_F, 1);
    chk("bne_d_live", d_live, 0);
`else
    chk("bne_squash_D", squash_D, 0);
    chk("bne_squash_F", squash_F, 0);
    chk("bne_d_live", d_live, 1);
`endif
    advance();
    redirect_x = 1'b0;
    sample();
`ifdef HAZARD_SQUASH_EN
    chk("bne_next_d_live", d_live, 0);
`else
    chk("bne_next_d_live", d_live, 1);
`endif
    advance();
    set_d(1, 0, 0, 0, 0, 1, 1, 0);
    redirect_d = 1'b1;
    sample();
`ifdef HAZARD_SQUASH_EN
    chk("jal_squash_F", squash_F, 1);
`else
    chk("jal_squash_F", squash_F, 0);
`endif
    chk("jal_squash_D", squash_D, 0);
    chk("jal_d_live", d_live, 1);
    advance();
    redirect_d = 1'b0;
    nops(3);

    // async reset mid-stream
    set_d(1, 0, 0, 0, 0, 1, 7, 0);
    sample();
    advance();
    nops(2);
    sample();
    chk("pre_arst_rf_wen", rf_wen_W, 1);
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    chk("arst_rf_wen", rf_wen_W, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    advance();
    rst = 1'b1;

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      set_d($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 2) == 0);
      x_busy     = ($urandom_range(0, 7) == 0);
      redirect_d = ($urandom_range(0, 5) == 0);
      redirect_x = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        m_reset();
      end else begin
        rst = 1'b1;
      end
      sample();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
